fft_da_rf_bank: RTL and testbench
=================================

FFT_DA_RF_BANK -- requirements
Module: fft_da_rf_bank

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 17, width of each real/imag sample.
- REQ-002 SHALL have parameter RF_DEPTH, default 8, words per register file (power of two, >=2).
- REQ-003 SHALL have parameter RF_NUM, default 8, number of register files (>=2).
- REQ-004 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
- REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
- REQ-006 SHALL have port wen_ctrl, input, RF_NUM, one-hot register-file write select.
- REQ-007 SHALL have port ren_ctrl, input, RF_NUM, one-hot register-file read select.
- REQ-008 SHALL have port waddr_ctrl, input, AW=$clog2(RF_DEPTH), explicit write address.
- REQ-009 SHALL have port raddr_ctrl, input, AW, read address.
- REQ-010 SHALL have port auto_waddr, input, 1, 1 = use internal write counter instead of waddr_ctrl.
- REQ-011 SHALL have port bitrev, input, 1, 1 = bit-reverse effective write address.
- REQ-012 SHALL have ports din_real/din_imag, input, DATA_WIDTH each, write data.
- REQ-013 SHALL have ports dout_real/dout_imag, output, DATA_WIDTH each, registered read data.
- REQ-014 SHALL have port dout_valid, output, 1, dout updated this cycle from a legal read.
- REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse when write counter wraps.
- REQ-016 SHALL have port sel_err, output, 1, one-cycle pulse on multi-hot wen_ctrl or ren_ctrl.

Function
- REQ-017 Write SHALL occur at clock edge when wen_ctrl is exactly one-hot: RF[i][eff_waddr] <= {din_real, din_imag}.
- REQ-018 eff_waddr SHALL be (auto_waddr ? wcnt : waddr_ctrl), then bit-reversed over AW bits if bitrev=1.
- REQ-019 wcnt SHALL increment by 1 per legal write while auto_waddr=1, wrap RF_DEPTH-1 -> 0; hold otherwise.
- REQ-020 frame_done SHALL pulse the cycle after the legal auto write with wcnt=RF_DEPTH-1.
- REQ-021 Deasserting auto_waddr SHALL NOT reset wcnt; only rst resets it.
- REQ-022 Read latency SHALL be 1 cycle: legal one-hot ren_ctrl at edge N -> dout/dout_valid=1 after edge N.
- REQ-023 ren_ctrl all-zero SHALL hold dout and drive dout_valid=0.
- REQ-024 Multi-hot wen_ctrl SHALL suppress the write, hold wcnt, pulse sel_err.
- REQ-025 Multi-hot ren_ctrl SHALL hold dout, drive dout_valid=0, pulse sel_err.
- REQ-026 Simultaneous read/write of same RF and address SHALL return the old (pre-write) data.
- REQ-027 Data SHALL be stored unmodified; no arithmetic, no saturation.

Reset
- REQ-028 rst SHALL asynchronously clear all RF words, dout_real, dout_imag, dout_valid, frame_done, sel_err, and wcnt to 0.
- REQ-029 rst mid-frame SHALL discard partial frame; first auto write after release goes to address 0 (bitrev(0)=0).

Configuration
- REQ-030 Macro DA_BITREV_EN defined: bitrev input honoured per REQ-018.
- REQ-031 DA_BITREV_EN undefined: bitrev ignored, eff_waddr un-reversed, no reversal logic synthesised.

Structure
- REQ-032 Package fft_da_pkg SHALL hold default DATA_WIDTH/RF_DEPTH/RF_NUM constants and complex-sample struct typedef.
- REQ-033 One sub-module fft_da_rf (single RF_DEPTH x 2*DATA_WIDTH register file, async-clear) SHALL be instantiated RF_NUM times.

Verification
- REQ-034 bitrev=1, auto_waddr=1, wen_ctrl[1]=1, din 0,4,2,6,1,5,3,7 -> frame_done one pulse after 8th write; RF1 reads addr 0..7 -> 0..7, dout_valid=1, 1-cycle latency.
- REQ-035 auto_waddr=0, bitrev=0, write RF4 addr 3 = 9, same-cycle read RF4 addr 3 -> old value 0; next read -> 9.
- REQ-036 wen_ctrl=8'b0000_0011 with din=5 -> sel_err pulse, no RF changed, wcnt unchanged.
- REQ-037 ren_ctrl=0 after valid read of 9 -> dout stays 9, dout_valid=0.
- REQ-038 rst asserted after 3 auto writes -> all outputs 0 immediately; next auto write lands at address 0.
- REQ-039 DA_BITREV_EN undefined, bitrev=1, auto write 0..7 -> RF[k]=k-th written value.

Source files
------------

// File: rtl/fft_da_pkg.sv
// Shared defaults and sample type for the FFT data-arrangement register-file bank.
package fft_da_pkg;
  localparam int DA_DATA_WIDTH = 17;
  localparam int DA_RF_DEPTH   = 8;
  localparam int DA_RF_NUM     = 8;

  typedef struct packed {
    logic [DA_DATA_WIDTH-1:0] re;
    logic [DA_DATA_WIDTH-1:0] im;
  } da_cplx_t;
endpackage

// File: rtl/fft_da_rf.sv
// Single RF_DEPTH x 2*DATA_WIDTH register file with one write port,
// a combinational read port, and an asynchronous clear.
module fft_da_rf
  import fft_da_pkg::*;
#(
  parameter int DATA_WIDTH = DA_DATA_WIDTH,
  parameter int RF_DEPTH   = DA_RF_DEPTH,
  localparam int AW        = $clog2(RF_DEPTH),
  localparam int WW        = 2 * DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WW-1:0] rdata
);

  logic [WW-1:0] mem_q [RF_DEPTH];
  logic [WW-1:0] mem_d [RF_DEPTH];

  always_comb begin
    for (int i = 0; i < RF_DEPTH; i++) mem_d[i] = mem_q[i];
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < RF_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write returns old data.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_da_rf_bank.sv
// Bank of RF_NUM register files with one-hot write/read select, auto write counter
// and registered read data. Define DA_BITREV_EN to honour the bitrev input.
module fft_da_rf_bank
  import fft_da_pkg::*;
#(
  parameter int DATA_WIDTH = DA_DATA_WIDTH,
  parameter int RF_DEPTH   = DA_RF_DEPTH,
  parameter int RF_NUM     = DA_RF_NUM,
  localparam int AW        = $clog2(RF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RF_NUM-1:0]     wen_ctrl,
  input  logic [RF_NUM-1:0]     ren_ctrl,
  input  logic [AW-1:0]         waddr_ctrl,
  input  logic [AW-1:0]         raddr_ctrl,
  input  logic                  auto_waddr,
  input  logic                  bitrev,
  input  logic [DATA_WIDTH-1:0] din_real,
  input  logic [DATA_WIDTH-1:0] din_imag,
  output logic [DATA_WIDTH-1:0] dout_real,
  output logic [DATA_WIDTH-1:0] dout_imag,
  output logic                  dout_valid,
  output logic                  frame_done,
  output logic                  sel_err
);

  localparam int WW = 2 * DATA_WIDTH;
  localparam logic [RF_NUM-1:0] SEL_ONE = RF_NUM'(1);
  localparam logic [AW-1:0] WCNT_LAST = AW'(RF_DEPTH - 1);

  logic wen_multi, ren_multi, wen_legal, ren_legal;
  logic [AW-1:0] base_waddr, eff_waddr;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic frame_done_q, frame_done_d;
  logic sel_err_q, sel_err_d;
  logic [WW-1:0] dout_q, dout_d;
  logic dout_valid_q, dout_valid_d;
  logic [WW-1:0] rf_rdata [RF_NUM];
  logic [WW-1:0] rd_sel;

  // x & (x-1) is non-zero exactly when more than one bit is set.
  assign wen_multi = |(wen_ctrl & (wen_ctrl - SEL_ONE));
  assign ren_multi = |(ren_ctrl & (ren_ctrl - SEL_ONE));
  assign wen_legal = (|wen_ctrl) & ~wen_multi;
  assign ren_legal = (|ren_ctrl) & ~ren_multi;

  assign base_waddr = auto_waddr ? wcnt_q : waddr_ctrl;

`ifdef DA_BITREV_EN
  always_comb begin
    eff_waddr = base_waddr;
    if (bitrev) begin
      for (int b = 0; b < AW; b++) eff_waddr[b] = base_waddr[AW-1-b];
    end
  end
`else
  logic unused_bitrev;
  assign unused_bitrev = bitrev;
  assign eff_waddr = base_waddr;
`endif

  always_comb begin
    wcnt_d       = wcnt_q;
    frame_done_d = 1'b0;
    if (wen_legal && auto_waddr) begin
      frame_done_d = (wcnt_q == WCNT_LAST);
      wcnt_d       = wcnt_q + AW'(1);
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < RF_NUM; i++) rd_sel = rd_sel | (rf_rdata[i] & {WW{ren_ctrl[i]}});
  end

  always_comb begin
    dout_d       = ren_legal ? rd_sel : dout_q;
    dout_valid_d = ren_legal;
    sel_err_d    = wen_multi | ren_multi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q       <= '0;
      frame_done_q <= 1'b0;
      sel_err_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wcnt_q       <= wcnt_d;
      frame_done_q <= frame_done_d;
      sel_err_q    <= sel_err_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  for (genvar g = 0; g < RF_NUM; g++) begin : g_rf
    fft_da_rf #(
      .DATA_WIDTH (DATA_WIDTH),
      .RF_DEPTH   (RF_DEPTH)
    ) u_rf (
      .clk   (clk),
      .rst   (rst),
      .we    (wen_legal & wen_ctrl[g]),
      .waddr (eff_waddr),
      .wdata ({din_real, din_imag}),
      .raddr (raddr_ctrl),
      .rdata (rf_rdata[g])
    );
  end

  assign dout_real  = dout_q[WW-1:DATA_WIDTH];
  assign dout_imag  = dout_q[DATA_WIDTH-1:0];
  assign dout_valid = dout_valid_q;
  assign frame_done = frame_done_q;
  assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_fft_da_rf_bank.sv
// Self-checking bench for fft_da_rf_bank: directed steps plus random traffic
// compared against an array-based reference model.
module tb_fft_da_rf_bank;
  localparam int DW = 17;
  localparam int D  = 8;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  wen_ctrl, ren_ctrl;
  logic [AW-1:0] waddr_ctrl, raddr_ctrl;
  logic          auto_waddr, bitrev;
  logic [DW-1:0] din_real, din_imag;
  logic [DW-1:0] dout_real, dout_imag;
  logic          dout_valid, frame_done, sel_err;

  always #5 clk = ~clk;

  fft_da_rf_bank #(.DATA_WIDTH(DW), .RF_DEPTH(D), .RF_NUM(N)) dut (
    .clk(clk), .rst(rst), .wen_ctrl(wen_ctrl), .ren_ctrl(ren_ctrl),
    .waddr_ctrl(waddr_ctrl), .raddr_ctrl(raddr_ctrl), .auto_waddr(auto_waddr),
    .bitrev(bitrev), .din_real(din_real), .din_imag(din_imag),
    .dout_real(dout_real), .dout_imag(dout_imag), .dout_valid(dout_valid),
    .frame_done(frame_done), .sel_err(sel_err)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [2*DW-1:0] m_mem [N][D];
  int              m_wcnt;
  logic [DW-1:0]   e_re, e_im;
  logic            e_valid, e_frame, e_sel;

  function automatic int rev(input int a);
    int r = 0;
    for (int b = 0; b < AW; b++) if (((a >> b) & 1) == 1) r = r | (1 << (AW - 1 - b));
    return r;
  endfunction

  function automatic int popcount(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    if (popcount(v) != 1) return -1;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".dout_real"},  64'(dout_real),  64'(e_re));
    chk({tag, ".dout_imag"},  64'(dout_imag),  64'(e_im));
    chk({tag, ".dout_valid"}, 64'(dout_valid), 64'(e_valid));
    chk({tag, ".frame_done"}, 64'(frame_done), 64'(e_frame));
    chk({tag, ".sel_err"},    64'(sel_err),    64'(e_sel));
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) for (int a = 0; a < D; a++) m_mem[i][a] = '0;
    m_wcnt = 0; e_re = '0; e_im = '0; e_valid = 0; e_frame = 0; e_sel = 0;
  endtask

  // Apply one cycle of inputs, predict the outcome from the model, then check.
  task automatic step(input logic [N-1:0] wen, input logic [N-1:0] ren,
                      input int wa, input int ra, input bit aw, input bit br,
                      input logic [DW-1:0] re, input logic [DW-1:0] im, input string tag);
    int wi, ri, addr;
    wen_ctrl = wen; ren_ctrl = ren;
    waddr_ctrl = AW'(wa); raddr_ctrl = AW'(ra);
    auto_waddr = aw; bitrev = br; din_real = re; din_imag = im;
    wi = onehot_idx(wen);
    ri = onehot_idx(ren);
    e_sel   = (popcount(wen) > 1) || (popcount(ren) > 1);
    e_valid = (ri >= 0);
    if (ri >= 0) {e_re, e_im} = m_mem[ri][ra];
    e_frame = 0;
    if (wi >= 0) begin
      addr = aw ? m_wcnt : wa;
`ifdef DA_BITREV_EN
      if (br) addr = rev(addr);
`endif
      m_mem[wi][addr] = {re, im};
      if (aw) begin
        e_frame = (m_wcnt == D - 1);
        m_wcnt  = (m_wcnt + 1) % D;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int seq [8];
    logic [31:0] r;
    logic [N-1:0] wv, rv;
    seq = '{0, 4, 2, 6, 1, 5, 3, 7};

    rst = 1'b1;
    wen_ctrl = '0; ren_ctrl = '0; waddr_ctrl = '0; raddr_ctrl = '0;
    auto_waddr = 1'b0; bitrev = 1'b0; din_real = '0; din_imag = '0;
    model_reset();
    #2;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Bit-reversed (or straight, without the macro) auto-addressed frame into RF1.
    for (int k = 0; k < 8; k++)
      step(8'b0000_0010, '0, 0, 0, 1'b1, 1'b1, DW'(seq[k]), DW'(100 + seq[k]), "frame_wr");
    for (int a = 0; a < 8; a++)
      step('0, 8'b0000_0010, 0, a, 1'b0, 1'b0, '0, '0, "frame_rd");
`ifdef DA_BITREV_EN
    step('0, 8'b0000_0010, 0, 5, 1'b0, 1'b0, '0, '0, "bitrev_addr5");
    chk("bitrev_addr5_value", 64'(dout_real), 64'd5);
`else
    step('0, 8'b0000_0010, 0, 5, 1'b0, 1'b0, '0, '0, "plain_addr5");
    chk("plain_addr5_value", 64'(dout_real), 64'd5);
`endif

    // Same-cycle read/write returns old data, then new data, then hold on idle.
    step(8'b0001_0000, 8'b0001_0000, 3, 3, 1'b0, 1'b0, DW'(9), DW'(9), "rw_same");
    step('0, 8'b0001_0000, 0, 3, 1'b0, 1'b0, '0, '0, "rd_after_wr");
    step('0, '0, 0, 0, 1'b0, 1'b0, '0, '0, "idle_hold");

    // Multi-hot selects: no write, no counter advance, read data held.
    step(8'b0000_0011, '0, 0, 0, 1'b1, 1'b0, DW'(5), DW'(5), "multi_wen");
    step('0, 8'b0101_0000, 0, 3, 1'b0, 1'b0, '0, '0, "multi_ren");
    step(8'b0000_0001, '0, 0, 0, 1'b1, 1'b0, DW'(77), DW'(78), "auto_after_multi");
    step('0, 8'b0000_0001, 0, 0, 1'b0, 1'b0, '0, '0, "rd_rf0_a0");
    step('0, 8'b0000_0010, 0, 0, 1'b0, 1'b0, '0, '0, "rd_rf1_a0");

    for (int t = 0; t < 400; t++) begin
      r = $urandom();
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: wv = N'(1) << $urandom_range(0, N - 1);
        6, 7:             wv = '0;
        default:          wv = r[N-1:0];
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: rv = N'(1) << $urandom_range(0, N - 1);
        6, 7:             rv = '0;
        default:          rv = r[2*N-1:N];
      endcase
      r = $urandom();
      step(wv, rv, $urandom_range(0, D - 1), $urandom_range(0, D - 1),
           ($urandom_range(0, 9) < 7), r[31], r[DW-1:0], DW'($urandom()), "random");
    end

    for (int i = 0; i < N; i++)
      for (int a = 0; a < D; a++)
        step(N'(1) << i, N'(1) << i, a, a, 1'b0, 1'b0, DW'(i * 16 + a), DW'(a), "sweep");

    // Asynchronous reset in the middle of a frame.
    for (int k = 0; k < 3; k++)
      step(8'b0000_0100, '0, 0, 0, 1'b1, 1'b0, DW'(200 + k), DW'(k), "pre_rst_wr");
    step('0, 8'b0000_0100, 0, 1, 1'b0, 1'b0, '0, '0, "pre_rst_rd");
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("rst_async");
    @(negedge clk);
    rst = 1'b0;
    step(8'b0000_0100, '0, 0, 0, 1'b1, 1'b1, DW'(17'h1234), DW'(17'h0abc), "post_rst_wr");
    step('0, 8'b0000_0100, 0, 0, 1'b0, 1'b0, '0, '0, "post_rst_rd_a0");
    chk("post_rst_a0_value", 64'(dout_real), 64'h1234);
    step('0, 8'b0000_0100, 0, 1, 1'b0, 1'b0, '0, '0, "post_rst_rd_a1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
